// File: rtl/axis_frame_fitter_if.sv
// AXI4-Stream video channel: valid/ready handshake, start-of-frame (tuser) and end-of-line (tlast).
interface axis_frame_fitter_if #(
    parameter int DATA_W = 8
);
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, tuser, tlast, tdata, input tready);
    modport slave  (input tvalid, tuser, tlast, tdata, output tready);
endinterface

// File: rtl/axis_frame_fitter.sv
// Forces every output frame to exactly img_width x img_height pixels (pad short, cut long, fill early-ended).
// Optional statistics counters are built when AXIS_FRAME_FITTER_STATS_EN is defined.
module axis_frame_fitter #(
    parameter int                         C_PIXEL_WIDTH = 8,
    parameter int                         C_IMG_WBITS   = 12,
    parameter int                         C_IMG_HBITS   = 12,
    parameter logic [C_PIXEL_WIDTH-1:0]   C_PAD_VALUE   = '0
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    axis_frame_fitter_if.slave     s_axis,
    axis_frame_fitter_if.master    m_axis,
    output logic                   frame_done,
    output logic [15:0]            pad_count,
    output logic [15:0]            drop_count
);
    typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_PAD, S_DROP, S_FILL} state_t;

    state_t                   state_q, state_d;
    logic [C_IMG_WBITS-1:0]   col_q, col_d, w_q, w_d, cur_w;
    logic [C_IMG_HBITS-1:0]   row_q, row_d, h_q, h_d, cur_h;
    logic                     vld_q, vld_d, user_q, user_d, last_q, last_d;
    logic                     final_q, final_d, done_q, done_d;
    logic [C_PIXEL_WIDTH-1:0] data_q, data_d;
    logic                     load, s_ready, emit, emit_pad, in_last, at_eol, at_eof;
    logic                     pad_evt, drop_evt;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        w_d      = w_q;
        h_d      = h_q;
        vld_d    = vld_q;
        user_d   = user_q;
        last_d   = last_q;
        data_d   = data_q;
        final_d  = final_q;
        s_ready  = 1'b0;
        emit     = 1'b0;
        emit_pad = 1'b0;
        in_last  = 1'b0;
        pad_evt  = 1'b0;
        drop_evt = 1'b0;
        cur_w    = w_q;
        cur_h    = h_q;
        load     = !vld_q || m_axis.tready;
        done_d   = vld_q && m_axis.tready && final_q;

        unique case (state_q)
            S_IDLE: begin
                // Stray pixels are swallowed freely; the sof pixel waits for the output register.
                s_ready = !s_axis.tuser || load;
                if (s_axis.tvalid) begin
                    if (!s_axis.tuser) begin
                        drop_evt = 1'b1;
                    end else if (load) begin
                        if (img_width == '0 || img_height == '0) begin
                            drop_evt = 1'b1;
                        end else begin
                            w_d     = img_width;
                            h_d     = img_height;
                            cur_w   = img_width;
                            cur_h   = img_height;
                            emit    = 1'b1;
                            in_last = s_axis.tlast;
                        end
                    end
                end
            end
            S_ACTIVE: begin
                s_ready = !s_axis.tuser && load;
                if (s_axis.tvalid) begin
                    if (s_axis.tuser) begin
                        state_d = S_FILL;
                    end else if (load) begin
                        emit    = 1'b1;
                        in_last = s_axis.tlast;
                    end
                end
            end
            S_PAD, S_FILL: begin
                if (load) begin
                    emit     = 1'b1;
                    emit_pad = 1'b1;
                    pad_evt  = 1'b1;
                end
            end
            S_DROP: begin
                s_ready = !s_axis.tuser;
                if (s_axis.tvalid) begin
                    if (s_axis.tuser) begin
                        state_d = S_FILL;
                    end else begin
                        drop_evt = 1'b1;
                        if (s_axis.tlast) state_d = S_ACTIVE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        at_eol = (col_q == cur_w - C_IMG_WBITS'(1));
        at_eof = at_eol && (row_q == cur_h - C_IMG_HBITS'(1));

        if (emit) begin
            vld_d   = 1'b1;
            data_d  = emit_pad ? C_PAD_VALUE : s_axis.tdata;
            user_d  = (row_q == '0) && (col_q == '0);
            last_d  = at_eol;
            final_d = at_eof;
            if (at_eol) begin
                col_d = '0;
                row_d = at_eof ? '0 : row_q + C_IMG_HBITS'(1);
            end else begin
                col_d = col_q + C_IMG_WBITS'(1);
            end
            if (at_eof)
                state_d = S_IDLE;
            else if (state_q == S_FILL)
                state_d = S_FILL;
            else if (state_q == S_PAD)
                state_d = at_eol ? S_ACTIVE : S_PAD;
            else if (at_eol)
                state_d = in_last ? S_ACTIVE : S_DROP;
            else
                state_d = in_last ? S_PAD : S_ACTIVE;
        end else if (load) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            vld_q   <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            final_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            w_q     <= w_d;
            h_q     <= h_d;
            vld_q   <= vld_d;
            user_q  <= user_d;
            last_q  <= last_d;
            data_q  <= data_d;
            final_q <= final_d;
            done_q  <= done_d;
        end
    end

    // Ready is combinational, so it is masked while reset is held.
    assign s_axis.tready = s_ready && !areset;
    assign m_axis.tvalid = vld_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tdata  = data_q;
    assign frame_done    = done_q;

`ifdef AXIS_FRAME_FITTER_STATS_EN
    logic [15:0] pad_cnt_q, pad_cnt_d, drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        pad_cnt_d  = sat_inc(pad_cnt_q, pad_evt);
        drop_cnt_d = sat_inc(drop_cnt_q, drop_evt);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pad_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pad_cnt_q  <= pad_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pad_count  = pad_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = pad_evt ^ drop_evt;
    assign pad_count  = '0;
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_axis_frame_fitter.sv
// Randomized bench for axis_frame_fitter against a frame-level reference model.
module tb_axis_frame_fitter;
    localparam logic [7:0] PADV = 8'hA5;

    logic        aclk = 1'b0;
    logic        areset;
    logic [11:0] img_width, img_height;
    logic        frame_done;
    logic [15:0] pad_count, drop_count;

    axis_frame_fitter_if #(.DATA_W(8)) s_axis ();
    axis_frame_fitter_if #(.DATA_W(8)) m_axis ();

    axis_frame_fitter #(
        .C_PIXEL_WIDTH(8), .C_IMG_WBITS(12), .C_IMG_HBITS(12), .C_PAD_VALUE(PADV)
    ) dut (
        .aclk(aclk), .areset(areset), .img_width(img_width), .img_height(img_height),
        .s_axis(s_axis), .m_axis(m_axis), .frame_done(frame_done),
        .pad_count(pad_count), .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    // Pixel entries are {tuser, tlast, tdata}.
    logic [9:0] in_q[$], exp_q[$], got_q[$];
    int vectors = 0, miscompares = 0;
    int exp_pads, exp_drops, fd_cnt, first_in, first_out, stall_bad;
    int pad_delta, drop_delta, exp_pad_delta, exp_drop_delta;
    bit timed_out;

    task automatic add_line(input int len, input bit sof, input bit with_last);
        for (int k = 0; k < len; k++)
            in_q.push_back({sof && k == 0, with_last && k == len - 1, 8'($urandom)});
    endtask

    task automatic add_frame(input int w, input int h);
        for (int r = 0; r < h; r++) add_line(w, r == 0, 1'b1);
    endtask

    // Reference: walk the input frame by frame, filling each w x h frame from the stream.
    task automatic model(input int w, input int h);
        int i, n, c;
        bit abort, padl;
        logic [9:0] e;
        exp_q.delete(); exp_pads = 0; exp_drops = 0; i = 0; n = in_q.size();
        while (i < n) begin
            if (!in_q[i][9]) begin exp_drops++; i++; continue; end
            abort = 0;
            for (int r = 0; r < h; r++) begin
                c = 0; padl = 0;
                while (c < w) begin
                    if (!abort && !padl && (i >= n || (in_q[i][9] && !(r == 0 && c == 0)))) abort = 1;
                    if (abort || padl) begin
                        exp_q.push_back({1'b0, c == w - 1, PADV}); exp_pads++; c++;
                    end else begin
                        e = in_q[i]; i++;
                        exp_q.push_back({r == 0 && c == 0, c == w - 1, e[7:0]}); c++;
                        if (c < w && e[8]) padl = 1;
                        else if (c == w && !e[8] && r != h - 1) begin
                            while (i < n) begin
                                if (in_q[i][9]) begin abort = 1; break; end
                                exp_drops++; e = in_q[i]; i++;
                                if (e[8]) break;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_stream(input int w, input int h, input int rdy_pct, input int vld_pct);
        int idx = 0, tail = 0;
        bit acc = 0, hold_v = 0;
        logic [9:0] hold;
        logic [15:0] pad0, drop0;
        img_width = 12'(w); img_height = 12'(h);
        model(w, h);
        got_q.delete(); fd_cnt = 0; first_in = -1; first_out = -1; stall_bad = 0; timed_out = 1;
        pad0 = pad_count; drop0 = drop_count;
        s_axis.tvalid = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge aclk);
            acc = s_axis.tvalid && s_axis.tready;
            if (acc) begin if (first_in < 0) first_in = cyc; idx++; end
            if (hold_v && (!m_axis.tvalid || {m_axis.tuser, m_axis.tlast, m_axis.tdata} !== hold))
                stall_bad++;
            hold_v = m_axis.tvalid && !m_axis.tready;
            hold = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
            if (m_axis.tvalid && m_axis.tready) begin
                if (first_out < 0) first_out = cyc;
                got_q.push_back({m_axis.tuser, m_axis.tlast, m_axis.tdata});
            end
            if (frame_done) fd_cnt++;
            if (idx == in_q.size() && got_q.size() >= exp_q.size()) tail++;
            if (tail == 3) begin timed_out = 0; break; end
            @(posedge aclk); #1;
            if (!(s_axis.tvalid && !acc)) begin
                if (idx < in_q.size() && $urandom_range(99) < vld_pct) begin
                    s_axis.tvalid = 1;
                    {s_axis.tuser, s_axis.tlast, s_axis.tdata} = in_q[idx];
                end else s_axis.tvalid = 0;
            end
            m_axis.tready = $urandom_range(99) < rdy_pct;
        end
        s_axis.tvalid = 0; m_axis.tready = 1;
        pad_delta = int'(16'(pad_count - pad0));
        drop_delta = int'(16'(drop_count - drop0));
`ifdef AXIS_FRAME_FITTER_STATS_EN
        exp_pad_delta = exp_pads; exp_drop_delta = exp_drops;
`else
        exp_pad_delta = 0; exp_drop_delta = 0;
`endif
    endtask

    task automatic test_reset();
        areset = 1; s_axis.tvalid = 1; s_axis.tuser = 0; s_axis.tlast = 0; s_axis.tdata = 8'h3C;
        m_axis.tready = 1; img_width = 4; img_height = 2;
        repeat (2) @(posedge aclk); #1;
        vectors++; if ({m_axis.tvalid, m_axis.tuser, m_axis.tlast} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {m_axis.tvalid, m_axis.tuser, m_axis.tlast}); end
        vectors++; if (m_axis.tdata !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", m_axis.tdata); end
        vectors++; if (s_axis.tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready got=%b exp=0", s_axis.tready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        vectors++; if ({pad_count, drop_count} !== 32'd0) begin miscompares++; $display("FAIL reset_stats got=%h exp=0", {pad_count, drop_count}); end
        @(negedge aclk); areset = 0; s_axis.tvalid = 0;
    endtask

    task automatic test_nominal();
        in_q.delete(); add_frame(4, 2);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL nominal_len got=%0d exp=%0d to=%0d", got_q.size(), exp_q.size(), timed_out); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k] || got_q[k] !== in_q[k]) begin miscompares++; $display("FAIL nominal_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        vectors++; if (first_out - first_in != 1) begin miscompares++; $display("FAIL nominal_latency got=%0d exp=1", first_out - first_in); end
        vectors++; if (fd_cnt != 1) begin miscompares++; $display("FAIL nominal_done got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_garbage();
        in_q.delete(); add_line(5, 1'b0, 1'b0); add_frame(4, 2);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != 8) begin miscompares++; $display("FAIL garbage_len got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL garbage_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        vectors++; if (drop_delta != exp_drop_delta) begin miscompares++; $display("FAIL garbage_drops got=%0d exp=%0d", drop_delta, exp_drop_delta); end
    endtask

    task automatic test_short_line();
        in_q.delete(); add_line(2, 1'b1, 1'b1); add_line(4, 1'b0, 1'b1);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != 8) begin miscompares++; $display("FAIL short_len got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL short_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        vectors++; if (got_q.size() > 3 && got_q[3] !== {2'b01, PADV}) begin miscompares++; $display("FAIL short_pad_last got=%h exp=%h", got_q[3], {2'b01, PADV}); end
        vectors++; if (pad_delta != exp_pad_delta) begin miscompares++; $display("FAIL short_pads got=%0d exp=%0d", pad_delta, exp_pad_delta); end
    endtask

    task automatic test_long_line();
        in_q.delete(); add_line(6, 1'b1, 1'b1); add_line(4, 1'b0, 1'b1);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != 8) begin miscompares++; $display("FAIL long_len got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL long_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        vectors++; if (drop_delta != exp_drop_delta) begin miscompares++; $display("FAIL long_drops got=%0d exp=%0d", drop_delta, exp_drop_delta); end
    endtask

    task automatic test_early_sof();
        in_q.delete(); add_line(4, 1'b1, 1'b1); add_line(1, 1'b0, 1'b0); add_frame(4, 2);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != 16) begin miscompares++; $display("FAIL early_len got=%0d exp=16", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL early_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
        vectors++; if (fd_cnt != 2) begin miscompares++; $display("FAIL early_done got=%0d exp=2", fd_cnt); end
    endtask

    task automatic test_w1h1();
        in_q.delete();
        for (int k = 0; k < 3; k++) add_line(1, 1'b1, k[0]);
        run_stream(1, 1, 70, 100);
        vectors++; if (timed_out || got_q.size() != 3) begin miscompares++; $display("FAIL w1h1_len got=%0d exp=3", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== {2'b11, in_q[k][7:0]}) begin miscompares++; $display("FAIL w1h1_px%0d got=%h exp=%h", k, got_q[k], {2'b11, in_q[k][7:0]}); end
        end
        vectors++; if (fd_cnt != 3) begin miscompares++; $display("FAIL w1h1_done got=%0d exp=3", fd_cnt); end
    endtask

    task automatic test_backpressure();
        for (int run = 0; run < 4; run++) begin
            int w = $urandom_range(6, 1), h = $urandom_range(4, 1), nfr = 0;
            in_q.delete();
            for (int s = 0; s < 12; s++) begin
                case ($urandom_range(3))
                    0: add_line($urandom_range(3, 1), 1'b0, $urandom_range(1));
                    1: add_frame(w, h);
                    default: add_line($urandom_range(w + 2, 1), $urandom_range(3) == 0, $urandom_range(4) != 0);
                endcase
            end
            add_frame(w, h);
            run_stream(w, h, 50, 80);
            foreach (exp_q[k]) if (exp_q[k][9]) nfr++;
            vectors++; if (timed_out || got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp%0d_len got=%0d exp=%0d", run, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL bp%0d_px%0d got=%h exp=%h", run, k, got_q[k], exp_q[k]); end
            end
            vectors++; if (stall_bad != 0) begin miscompares++; $display("FAIL bp%0d_stall_hold got=%0d exp=0", run, stall_bad); end
            vectors++; if (fd_cnt != nfr) begin miscompares++; $display("FAIL bp%0d_done got=%0d exp=%0d", run, fd_cnt, nfr); end
            vectors++; if (pad_delta != exp_pad_delta || drop_delta != exp_drop_delta) begin
                miscompares++; $display("FAIL bp%0d_stats got=%0d/%0d exp=%0d/%0d", run, pad_delta, drop_delta, exp_pad_delta, exp_drop_delta);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        img_width = 4; img_height = 2; m_axis.tready = 0;
        @(posedge aclk); #1;
        s_axis.tvalid = 1; s_axis.tuser = 1; s_axis.tlast = 0; s_axis.tdata = 8'h11;
        @(posedge aclk); #1;
        s_axis.tvalid = 0;
        @(negedge aclk);
        vectors++; if ({m_axis.tvalid, m_axis.tuser} !== 2'b11) begin miscompares++; $display("FAIL midrst_pre got=%b exp=11", {m_axis.tvalid, m_axis.tuser}); end
        areset = 1; #1;
        vectors++; if ({m_axis.tvalid, m_axis.tdata} !== 9'd0) begin miscompares++; $display("FAIL midrst_clear got=%h exp=0", {m_axis.tvalid, m_axis.tdata}); end
        @(negedge aclk); areset = 0; m_axis.tready = 1;
        in_q.delete(); add_line(2, 1'b0, 1'b1); add_frame(4, 2);
        run_stream(4, 2, 100, 100);
        vectors++; if (timed_out || got_q.size() != 8) begin miscompares++; $display("FAIL midrst_len got=%0d exp=8", got_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            vectors++; if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL midrst_px%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_garbage();
        test_short_line();
        test_long_line();
        test_early_sof();
        test_w1h1();
        test_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
